// File: rtl/adder_pipelined.sv
// adder_pipelined: valid/ready pipelined add/sub, carry chain split into STAGES slices.
// Optional ADDER_OVERFLOW_EN adds a registered signed-overflow output Ovf_reg.
module adder_pipelined #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   input  logic             Valid_in,
   output logic             Ready_in,
   output logic [WIDTH-1:0] Sum_reg,
   output logic             Carry_reg,
`ifdef ADDER_OVERFLOW_EN
   output logic             Ovf_reg,
`endif
   output logic             Valid_out,
   input  logic             Ready_out
);
   localparam int SW = WIDTH / STAGES;
   logic              adv;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  sum_in [STAGES];
   logic [STAGES-1:0] valid_q, valid_d, c_q, c_d, c_in;
   logic [SW:0]       slice;
`ifdef ADDER_OVERFLOW_EN
   logic              ovf_q, ovf_d;
`endif
   always_comb begin
      adv       = !valid_q[STAGES-1] || Ready_out;
      a_in[0]   = A;
      b_in[0]   = Sub ? ~B : B;
      c_in[0]   = Sub;
      sum_in[0] = '0;
      valid_d[0] = Valid_in;
      for (int s = 1; s < STAGES; s++) begin
         a_in[s]    = a_q[s-1];
         b_in[s]    = b_q[s-1];
         c_in[s]    = c_q[s-1];
         sum_in[s]  = sum_q[s-1];
         valid_d[s] = valid_q[s-1];
      end
      slice = '0;
      // each stage resolves its own slice; upper operand bits ride along untouched
      for (int s = 0; s < STAGES; s++) begin
         slice = {1'b0, a_in[s][s*SW +: SW]} + {1'b0, b_in[s][s*SW +: SW]} + (SW+1)'(c_in[s]);
         a_d[s]   = a_in[s];
         b_d[s]   = b_in[s];
         sum_d[s] = sum_in[s];
         sum_d[s][s*SW +: SW] = slice[SW-1:0];
         c_d[s]   = slice[SW];
      end
`ifdef ADDER_OVERFLOW_EN
      // carry into the MSB recovered from its sum bit, xor carry out
      ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1] ^ sum_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
`endif
   end
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         valid_q <= '0;
         c_q     <= '0;
         for (int s = 0; s < STAGES; s++) begin
            a_q[s]   <= '0;
            b_q[s]   <= '0;
            sum_q[s] <= '0;
         end
`ifdef ADDER_OVERFLOW_EN
         ovf_q <= 1'b0;
`endif
      end else if (adv) begin
         valid_q <= valid_d;
         for (int s = 0; s < STAGES; s++) begin
            if (s > 0 || Valid_in) begin
               a_q[s]   <= a_d[s];
               b_q[s]   <= b_d[s];
               sum_q[s] <= sum_d[s];
               c_q[s]   <= c_d[s];
            end
         end
`ifdef ADDER_OVERFLOW_EN
         if (STAGES > 1 || Valid_in) ovf_q <= ovf_d;
`endif
      end
   end
   assign Ready_in  = adv;
   assign Sum_reg   = sum_q[STAGES-1];
   assign Carry_reg = c_q[STAGES-1];
   assign Valid_out = valid_q[STAGES-1];
`ifdef ADDER_OVERFLOW_EN
   assign Ovf_reg   = ovf_q;
`endif
endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined: directed checks of adder_pipelined (WIDTH=8, STAGES=2) with an ordered result queue.
module tb_adder_pipelined;
   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       Sub = 1'b0, Valid_in = 1'b0, Ready_out = 1'b0;
   logic       Ready_in, Carry_reg, Valid_out;
   logic [7:0] Sum_reg;
`ifdef ADDER_OVERFLOW_EN
   logic       Ovf_reg;
`endif
   int         total = 0, bad = 0, outs = 0, o0;
   logic [9:0] q [$];
   logic [9:0] ex;
   logic       acc;
   logic [7:0] ra, rb;
   logic       rs;

   adder_pipelined #(.WIDTH(8), .STAGES(2)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Sub(Sub), .Valid_in(Valid_in),
      .Ready_in(Ready_in), .Sum_reg(Sum_reg), .Carry_reg(Carry_reg),
`ifdef ADDER_OVERFLOW_EN
      .Ovf_reg(Ovf_reg),
`endif
      .Valid_out(Valid_out), .Ready_out(Ready_out)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // expected {ovf, carry, sum}
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [7:0] bb;
      logic [8:0] r;
      bb = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + 9'(s);
      return {(a[7] == bb[7]) && (r[7] != a[7]), r};
   endfunction

   task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic r, input logic [9:0] e);
      @(negedge Clk);
      Valid_in = v; A = a; B = b; Sub = s; Ready_out = r;
      #1;
      acc = v && Ready_in;
      if (acc) q.push_back(e);
      if (Valid_out && Ready_out) begin
         if (q.size() == 0) chk("extra_result", Valid_out, 0);
         else begin
            ex = q.pop_front();
            outs++;
            chk("sum", Sum_reg, ex[7:0]);
            chk("carry", Carry_reg, ex[8]);
`ifdef ADDER_OVERFLOW_EN
            chk("ovf", Ovf_reg, ex[9]);
`endif
         end
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [9:0] e);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, a, b, s, 1'b1, e);
         if (acc) return;
      end
      chk("send_timeout", acc, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 10'h0);
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_vout", Valid_out, 0);
      chk("rst_sum", Sum_reg, 0);
      chk("rst_carry", Carry_reg, 0);
      chk("rst_ready", Ready_in, 1);
      @(negedge Clk);
      Rst_n = 1'b1;
      // carry ripples across the slice boundary; latency two edges
      cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00});
      idle(1);
      chk("t1_lat1", Valid_out, 0);
      idle(1);
      chk("t1_vout", Valid_out, 1);
      chk("t1_sum", Sum_reg, 8'h00);
      chk("t1_carry", Carry_reg, 1);
      send(8'h05, 8'h07, 1'b1, {1'b0, 1'b0, 8'hFE});
      send(8'h07, 8'h05, 1'b1, {1'b0, 1'b1, 8'h02});
      idle(3);
      chk("t2_count", outs, 3);
      // back-to-back stream
      o0 = outs;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs));
         end else idle(1);
         if (i >= 2) chk("t3_vout", Valid_out, 1);
      end
      chk("t3_count", outs - o0, 16);
      idle(2);
      // stall mid-stream
      o0 = outs;
      send(8'h11, 8'h22, 1'b0, {1'b0, 1'b0, 8'h33});
      send(8'hF0, 8'h20, 1'b0, {1'b0, 1'b1, 8'h10});
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
         chk("t4_ready", Ready_in, 0);
         chk("t4_vout", Valid_out, 1);
         chk("t4_hold_sum", Sum_reg, 8'h33);
         chk("t4_hold_carry", Carry_reg, 0);
      end
      send(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
      send(8'h0F, 8'h01, 1'b1, {1'b0, 1'b1, 8'h0E});
      idle(4);
      chk("t4_count", outs - o0, 4);
      chk("t4_queue", q.size(), 0);
      // async reset with two in flight
      send(8'h33, 8'h44, 1'b0, {1'b0, 1'b0, 8'h77});
      send(8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03});
      @(negedge Clk);
      Valid_in = 1'b0; Ready_out = 1'b0; Rst_n = 1'b0;
      #1;
      chk("t5_rst_vout", Valid_out, 0);
      chk("t5_rst_sum", Sum_reg, 0);
      q.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("t5_no_ghost", Valid_out, 0);
      end
      cyc(1'b1, 8'h0A, 8'h05, 1'b0, 1'b1, {1'b0, 1'b0, 8'h0F});
      idle(1);
      chk("t5_lat1", Valid_out, 0);
      idle(1);
      chk("t5_vout", Valid_out, 1);
      chk("t5_sum", Sum_reg, 8'h0F);
      idle(2);
      chk("t5_queue", q.size(), 0);
`ifdef ADDER_OVERFLOW_EN
      send(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
      send(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F});
      idle(3);
      chk("t6_queue", q.size(), 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
